// File: rtl/uart_tx_if.sv
// Parallel-side handshake and serial status bundle for uart_tx.
// The master drives data/start; the slave (transmitter) returns line and status.
interface uart_tx_if #(
  parameter int DATA_SIZE = 8
) ();
  logic [DATA_SIZE-1:0] data;
  logic                 start;
  logic                 ready;
  logic                 out;
  logic                 is_transmitting;
  logic                 is_completed;

  modport master (
    output data,
    output start,
    input  ready,
    input  out,
    input  is_transmitting,
    input  is_completed
  );

  modport slave (
    input  data,
    input  start,
    output ready,
    output out,
    output is_transmitting,
    output is_completed
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_SIZE bits LSB first, optional even parity, one stop bit.
// Optional parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_tx #(
  parameter int FREQ      = 1_000_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_SIZE = 8
) (
  input logic      clk,
  input logic      reset,
  uart_tx_if.slave bus
);
  localparam int BIT_CYCLES = FREQ / BAUD;
  localparam int CNT_W      = (BIT_CYCLES < 2) ? 1 : $clog2(BIT_CYCLES);
  localparam int IDX_W      = $clog2(DATA_SIZE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_SIZE - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  if (BIT_CYCLES < 2) begin : g_bad_cfg
    $error("uart_tx: FREQ/BAUD must be at least 2");
  end

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif
  logic                 out_q, out_d;
  logic                 ready_q, ready_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 accept_s;
  logic                 bit_end_s;

  assign accept_s  = bus.start && ready_q;
  assign bit_end_s = (cnt_q == CNT_LAST);

  // Next-state, bit timing and shift register; the counter restarts on every acceptance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = START;
          cnt_d   = '0;
          idx_d   = '0;
          shift_d = bus.data;
`ifdef UART_TX_PARITY_EN
          par_d   = ^bus.data;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_d = DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          state_d = STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (bit_end_s) begin
          cnt_d = '0;
          idx_d = '0;
          // A request in the final stop cycle chains the next frame with no idle gap.
          if (accept_s) begin
            state_d = START;
            shift_d = bus.data;
`ifdef UART_TX_PARITY_EN
            par_d   = ^bus.data;
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        shift_d = '0;
      end
    endcase
  end

  // Outputs are derived from the upcoming state so the registered copies line up with it.
  always_comb begin
    out_d = 1'b1;
    case (state_d)
      START:   out_d = 1'b0;
      DATA:    out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  out_d = par_d;
`endif
      STOP:    out_d = 1'b1;
      IDLE:    out_d = 1'b1;
      default: out_d = 1'b1;
    endcase
    if ((state_d == STOP) && (cnt_d == CNT_LAST)) begin
      done_d = 1'b1;
    end else begin
      done_d = 1'b0;
    end
    if ((state_d == IDLE) || done_d) begin
      ready_d = 1'b1;
    end else begin
      ready_d = 1'b0;
    end
    if (state_d != IDLE) begin
      tx_d = 1'b1;
    end else begin
      tx_d = 1'b0;
    end
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
      out_q   <= 1'b1;
      ready_q <= 1'b1;
      tx_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
      out_q   <= out_d;
      ready_q <= ready_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign bus.out             = out_q;
  assign bus.ready           = ready_q;
  assign bus.is_transmitting = tx_q;
  assign bus.is_completed    = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx (FREQ=8, BAUD=1, DATA_SIZE=8): vector table, corner sequences, random frames.
module tb_uart_tx;
  localparam int BC = 8;
  localparam int DS = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME_CYC = (2 + DS + PB) * BC;

  typedef struct {
    logic [7:0] data;
    bit         toggle;
    int         busy_at;
    logic       exp_par;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  vec_t vecs [8];

  uart_tx_if #(.DATA_SIZE(DS)) bus ();

  uart_tx #(.FREQ(8), .BAUD(1), .DATA_SIZE(DS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Line level in bit period pos of a frame carrying w.
  function automatic logic model_bit(input logic [7:0] w, input int pos, input logic par);
    if (pos == 0) return 1'b0;
    else if (pos <= DS) return w[pos-1];
    else if (PB == 1 && pos == DS + 1) return par;
    else return 1'b1;
  endfunction

  function automatic logic [3:0] status();
    return {bus.out, bus.ready, bus.is_transmitting, bus.is_completed};
  endfunction

  task automatic run_frame(input logic [7:0] word, input bit toggle, input int busy_at,
                           input logic par, input string name);
    int first_bad = 0;
    int comp_cnt = 0;
    int comp_at = 0;
    int tx_bad = 0;
    int rdy_bad = 0;
    check({name, "_ready_pre"}, {31'd0, bus.ready}, 32'd1);
    bus.data  = word;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= FRAME_CYC; c++) begin
      if (bus.out !== model_bit(word, (c - 1) / BC, par) && first_bad == 0) first_bad = c;
      if (bus.is_transmitting !== 1'b1 && tx_bad == 0) tx_bad = c;
      if (bus.is_completed === 1'b1) begin
        comp_cnt++;
        comp_at = c;
      end
      if (bus.ready !== (c == FRAME_CYC) && rdy_bad == 0) rdy_bad = c;
      if (toggle) bus.data = ~bus.data;
      if (busy_at != 0) begin
        bus.start = (c == busy_at);
        if (c == busy_at) bus.data = 8'h3C;
      end
      tick();
    end
    check({name, "_wave_first_bad_cycle"}, first_bad, 32'd0);
    check({name, "_tx_drop_cycle"}, tx_bad, 32'd0);
    check({name, "_ready_bad_cycle"}, rdy_bad, 32'd0);
    check({name, "_done_count"}, comp_cnt, 32'd1);
    check({name, "_done_cycle"}, comp_at, FRAME_CYC);
    check({name, "_idle_after"}, {28'd0, status()}, 32'hC);
  endtask

  initial begin
    int busy;
    int first_bad;
    int tx_bad;
    int comp_cnt;
    int rst_bad;
    logic [7:0] w;

    total = 0;
    bad   = 0;
    vecs[0] = '{8'hA5, 1'b0, 0,  1'b0};
    vecs[1] = '{8'h07, 1'b0, 0,  1'b1};
    vecs[2] = '{8'h81, 1'b1, 0,  1'b0};
    vecs[3] = '{8'h55, 1'b0, 20, 1'b0};
    vecs[4] = '{8'h00, 1'b0, 0,  1'b0};
    vecs[5] = '{8'hFF, 1'b0, 0,  1'b0};
    vecs[6] = '{8'h01, 1'b0, 0,  1'b1};
    vecs[7] = '{8'hFE, 1'b1, 0,  1'b1};

    reset     = 1'b0;
    bus.start = 1'b0;
    bus.data  = 8'h00;
    tick();
    tick();
    check("reset_state", {28'd0, status()}, 32'hC);
    reset = 1'b1;
    tick();
    check("idle_after_release", {28'd0, status()}, 32'hC);

    foreach (vecs[i]) begin
      run_frame(vecs[i].data, vecs[i].toggle, vecs[i].busy_at, vecs[i].exp_par,
                $sformatf("vec%0d", i));
      if (vecs[i].busy_at != 0) begin
        busy = 0;
        for (int k = 0; k < 2 * BC; k++) begin
          if (bus.is_transmitting === 1'b1) busy++;
          tick();
        end
        check("busy_no_second_frame", busy, 32'd0);
      end
    end

    // Back-to-back: start held high across the final stop cycle.
    bus.data  = 8'h00;
    bus.start = 1'b1;
    tick();
    bus.data  = 8'hFF;
    busy = 0;
    first_bad = 0;
    tx_bad = 0;
    comp_cnt = 0;
    for (int c = 1; c <= 2 * FRAME_CYC + 2 * BC; c++) begin
      if (c <= 2 * FRAME_CYC) begin
        if (c <= FRAME_CYC) begin
          if (bus.out !== model_bit(8'h00, (c - 1) / BC, 1'b0) && first_bad == 0) first_bad = c;
        end else begin
          if (bus.out !== model_bit(8'hFF, (c - FRAME_CYC - 1) / BC, 1'b0) && first_bad == 0)
            first_bad = c;
        end
        if (bus.is_transmitting !== 1'b1 && tx_bad == 0) tx_bad = c;
      end
      if (bus.is_transmitting === 1'b1) busy++;
      if (bus.is_completed === 1'b1) comp_cnt++;
      if (c == FRAME_CYC + 1) bus.start = 1'b0;
      tick();
    end
    check("b2b_wave_first_bad_cycle", first_bad, 32'd0);
    check("b2b_tx_drop_cycle", tx_bad, 32'd0);
    check("b2b_busy_cycles", busy, 2 * FRAME_CYC);
    check("b2b_done_count", comp_cnt, 32'd2);

    // Mid-frame reset at cycle 30, then a word presented right at release.
    bus.data  = 8'h5A;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 30; c++) tick();
    check("pre_reset_busy", {31'd0, bus.is_transmitting}, 32'd1);
    reset = 1'b0;
    #1;
    check("reset_async_status", {28'd0, status()}, 32'hC);
    rst_bad = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (status() !== 4'hC) rst_bad++;
    end
    check("reset_hold_status", rst_bad, 32'd0);
    reset = 1'b1;
    run_frame(8'hC3, 1'b0, 0, 1'b0, "after_reset");

    // Random words with random idle gaps and optional data toggling.
    for (int n = 0; n < 12; n++) begin
      w = 8'($urandom_range(0, 255));
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
      run_frame(w, 1'($urandom_range(0, 1)), 0, ^w, $sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter FREQ, default 1e9, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line rate in bit/s.
REQ-003 SHALL have parameter DATA_SIZE, default 8, data bits per frame (1..16).
REQ-004 SHALL have port clk  input  1  system clock; all state updates on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted, 1 = run).
REQ-006 SHALL have port data  input  DATA_SIZE  word to send; sampled only on acceptance.
REQ-007 SHALL have port start  input  1  request to send data.
REQ-008 SHALL have port ready  output  1  high when a new word can be accepted.
REQ-009 SHALL have port out  output  1  serial line; idle level 1.
REQ-010 SHALL have port is_transmitting  output  1  high from the first start-bit cycle through the last stop-bit cycle.
REQ-011 SHALL have port is_completed  output  1  one-cycle pulse in the last stop-bit cycle.

Function
REQ-012 SHALL use BIT_CYCLES = FREQ/BAUD, truncated to an integer, as the bit period in clk cycles; BIT_CYCLES < 2 is a configuration error.
REQ-013 SHALL accept a word on a posedge where start=1 and ready=1, latching data into an internal shift register.
REQ-014 SHALL ignore start while ready=0; requests are not queued.
REQ-015 SHALL ignore changes on data after acceptance.
REQ-016 SHALL use the states IDLE, START, DATA, PARITY (present only with the macro), STOP; IDLE->START on acceptance; START->DATA after BIT_CYCLES; DATA->PARITY or STOP after DATA_SIZE bit periods; PARITY->STOP after BIT_CYCLES; STOP->IDLE after BIT_CYCLES.
REQ-017 SHALL drive out=0 for BIT_CYCLES cycles starting the cycle after acceptance, giving a latency of 1 cycle.
REQ-018 SHALL send the data bits LSB first, each held for exactly BIT_CYCLES cycles.
REQ-019 SHALL drive one stop bit, out=1, for BIT_CYCLES cycles.
REQ-020 SHALL restart the bit counter at 0 on every acceptance, with no free-running strobe phase; every bit is exactly BIT_CYCLES long with no cumulative drift.
REQ-021 SHALL drive ready=1 in IDLE and in the last STOP cycle, and ready=0 otherwise.
REQ-022 SHALL, when start=1 in the last STOP cycle, accept the new word and drive its start bit on the next cycle, giving back-to-back frames with no idle gap; in that case is_transmitting stays 1.
REQ-023 SHALL register out so the output is glitch-free; out=1 in IDLE.
REQ-024 SHALL size the bit-period counter as ceil(log2(BIT_CYCLES)) bits and the bit index as ceil(log2(DATA_SIZE+1)) bits.

Reset
REQ-025 SHALL, while reset=0, immediately force out=1, ready=1, is_transmitting=0, is_completed=0, state=IDLE, and clear all counters and the shift register.
REQ-026 SHALL abandon a frame on reset assertion mid-frame, with no completion pulse, and SHALL NOT resume that frame after release.
REQ-027 SHALL accept a word on the first posedge after reset release if start=1.

Configuration
REQ-028 SHALL, with UART_TX_PARITY_EN defined, insert one even-parity bit after the last data bit, held BIT_CYCLES cycles; the bit equals the XOR of the latched data bits.
REQ-029 SHALL, without UART_TX_PARITY_EN, omit the PARITY state and its logic, so the frame is 1+DATA_SIZE+1 bit periods.

Verification (FREQ=8, BAUD=1, DATA_SIZE=8 -> BIT_CYCLES=8)
REQ-030 SHALL check single frame: start pulse with data=0xA5 -> out = 0,1,0,1,0,0,1,0,1,1, each for 8 cycles starting 1 cycle after acceptance; is_completed pulses once in cycle 80 after acceptance; ready returns 1 in that cycle.
REQ-031 SHALL check back-to-back: start held 1 with data=0x00 then 0xFF -> the second start bit directly follows the first stop bit; is_transmitting never drops between frames; total 160 busy cycles.
REQ-032 SHALL check busy request: start=1 with data=0x3C at cycle 20 of a 0x55 frame -> 0x3C is ignored; the 0x55 waveform is unchanged; no second frame is sent.
REQ-033 SHALL check mid-frame reset: reset=0 at cycle 30 of a frame -> out=1 and ready=1 in the same cycle, before the clock edge; no is_completed pulse; after release, the next word is sent correctly.
REQ-034 SHALL check parity build: UART_TX_PARITY_EN defined, data=0xA5 -> parity bit 0 and an 88-cycle frame; with data=0x07 -> parity bit 1.
REQ-035 SHALL check data-hold: data toggled every cycle after acceptance of 0x81 -> the line still carries 0x81.
